// File: rtl/riscv_mc_defs_pkg.sv
// riscv_mc_defs: shared encodings for the multi-cycle RV32 control path
// (states, opcodes, ALU codes, operand selects, fault codes).
package riscv_mc_defs;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_TRAP
    } state_t;

    typedef enum logic [2:0] {CLS_ADD, CLS_R, CLS_I, CLS_MEM, CLS_BR} alu_cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: maps the execute class and function bits to an ALU op and a legality flag.
module mc_alu_decode
    import riscv_mc_defs::*;
(
    input  alu_cls_t   cls,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl,
    output logic       legal
);
    logic       arith_ok;
    logic [3:0] arith_op;

    assign arith_ok = funct3 inside {3'b000, 3'b110, 3'b111};
    // funct7b5 selects SUB only for register-register ops; immediates ignore it
    assign arith_op = funct3 == 3'b111 ? ALU_AND :
                      funct3 == 3'b110 ? ALU_OR  :
                      (cls == CLS_R && funct7b5) ? ALU_SUB : ALU_ADD;

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (cls)
            CLS_R, CLS_I: begin alu_ctrl = arith_op; legal = arith_ok; end
            CLS_MEM:      legal = funct3 == 3'b010;
            CLS_BR:       begin alu_ctrl = ALU_SUB; legal = funct3 == 3'b000; end
            default:      ;
        endcase
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32 sequencer stepping each instruction FETCH..WB,
// with a variable-latency memory handshake, a wait timeout and a sticky fault.
module mc_ctrl_fsm
    import riscv_mc_defs::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic       instr_retired,
    output logic [1:0] fault,
    output logic [3:0] state_dbg
);
    state_t           state, state_nx, after;
    alu_cls_t         cls;
    logic [1:0]       fault_nx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       dec_ctrl;
    logic             legal, timeout;

    mc_alu_decode u_dec (.cls(cls), .funct3(funct3), .funct7b5(funct7b5), .alu_ctrl(dec_ctrl), .legal(legal));

    assign state_dbg = state;
    assign after     = run ? S_FETCH : S_IDLE;
    // a ready on the final waiting cycle completes the access instead of trapping
    assign timeout   = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && cnt == CNT_W'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            fault <= FAULT_NONE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            fault <= fault_nx;
            cnt   <= (state_nx != state || mem_ready || !mem_req) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx      = state;
        fault_nx      = fault;
        cls           = CLS_ADD;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_ctrl      = ALU_AND;
        instr_retired = 1'b0;
        case (state)
            S_IDLE: state_nx = after;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_ctrl  = ALU_ADD;
                    state_nx  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = ALU_ADD;
                state_nx  = opcode == OP_R ? S_EXEC_R :
                            opcode == OP_IMM ? S_EXEC_I :
                            (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEM_ADDR :
                            opcode == OP_BRANCH ? S_BRANCH : S_TRAP;
                fault_nx  = state_nx == S_TRAP ? FAULT_ILLEGAL : fault;
            end
            S_EXEC_R, S_EXEC_I: begin
                cls       = state == S_EXEC_R ? CLS_R : CLS_I;
                alu_src_a = SRCA_RS1;
                alu_src_b = state == S_EXEC_R ? SRCB_RS2 : SRCB_IMM;
                alu_ctrl  = dec_ctrl;
                state_nx  = legal ? S_WB_ALU : S_TRAP;
                fault_nx  = legal ? fault : FAULT_ILLEGAL;
            end
            S_MEM_ADDR: begin
                cls       = CLS_MEM;
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = dec_ctrl;
                state_nx  = !legal ? S_TRAP : opcode == OP_STORE ? S_MEM_WR : S_MEM_RD;
                fault_nx  = legal ? fault : FAULT_ILLEGAL;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                state_nx = mem_ready ? S_WB_MEM : state;
            end
            S_MEM_WR: begin
                mem_req       = 1'b1;
                mem_we        = 1'b1;
                iord          = 1'b1;
                instr_retired = mem_ready;
                state_nx      = mem_ready ? after : state;
            end
            S_WB_ALU, S_WB_MEM: begin
                reg_write     = 1'b1;
                mem_to_reg    = state == S_WB_MEM;
                instr_retired = 1'b1;
                state_nx      = after;
            end
            S_BRANCH: begin
                cls           = CLS_BR;
                alu_src_a     = SRCA_RS1;
                alu_ctrl      = dec_ctrl;
                pc_src        = 1'b1;
                pc_write      = legal && zero;
                instr_retired = legal;
                state_nx      = legal ? after : S_TRAP;
                fault_nx      = legal ? fault : FAULT_ILLEGAL;
            end
            S_TRAP: ;
            default: state_nx = S_IDLE;
        endcase
        if (timeout) begin
            state_nx = S_TRAP;
            fault_nx = FAULT_TIMEOUT;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized scoreboard bench; a stall-injecting memory responder, a per-instruction
// reference model of latency/strobes/faults, and a monitor that checks each retirement or trap.
module tb_mc_ctrl_fsm;
    import riscv_mc_defs::*;

    localparam int TMO = 4;

    typedef struct {
        bit         trap;
        logic [1:0] fault;
        int         lat;
        logic [3:0] alu;
        bit         rw, m2r, we, pcw, br;
    } exp_t;

    logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg, instr_retired;
    logic [1:0] alu_src_a, alu_src_b, fault;
    logic [3:0] alu_ctrl, state_dbg;
    logic [18:0] outs;

    int   tests = 0, fails = 0, done_cnt = 0, fw = 0, dw = 0, wcnt = 0;
    exp_t exp_q[$];
    logic [2:0] legal_f3 [3] = '{3'b000, 3'b110, 3'b111};

    bit         busy = 1'b0, prev_wait = 1'b0;
    int         cyc = 0;
    logic [3:0] ex_alu = 4'hf;
    logic [2:0] prev_acc = '0;

    mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .instr_retired(instr_retired), .fault(fault), .state_dbg(state_dbg)
    );

    assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, mem_to_reg,
                   alu_src_a, alu_src_b, alu_ctrl, instr_retired, fault};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected outcome of one instruction given its fields and memory wait counts.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic z, input int fwt, input int dwt);
        exp_t e;
        bit   arith_ok;
        logic [3:0] arith;
        e = '{trap: 1'b1, fault: 2'b01, lat: fwt + 4, alu: 4'h0, rw: 1'b0, m2r: 1'b0, we: 1'b0, pcw: 1'b0, br: 1'b0};
        arith_ok = f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111;
        arith = f3 == 3'b111 ? ALU_AND : f3 == 3'b110 ? ALU_OR : ALU_ADD;
        if (fwt >= TMO) begin
            e.fault = 2'b10;
            e.lat   = TMO + 1;
            return e;
        end
        case (op)
            OP_R, OP_IMM: if (arith_ok) begin
                e.trap = 1'b0; e.fault = 2'b00; e.rw = 1'b1;
                e.alu  = (op == OP_R && f3 == 3'b000 && f7) ? ALU_SUB : arith;
            end
            OP_LOAD, OP_STORE: if (f3 == 3'b010) begin
                if (dwt >= TMO) begin
                    e.fault = 2'b10;
                    e.lat   = fwt + 4 + TMO;
                end else begin
                    e.trap = 1'b0; e.fault = 2'b00; e.alu = ALU_ADD;
                    e.rw   = op == OP_LOAD; e.m2r = op == OP_LOAD; e.we = op == OP_STORE;
                    e.lat  = fwt + dwt + (op == OP_LOAD ? 5 : 4);
                end
            end
            OP_BRANCH: if (f3 == 3'b000) begin
                e.trap = 1'b0; e.fault = 2'b00; e.alu = ALU_SUB; e.pcw = z; e.br = 1'b1; e.lat = fwt + 3;
            end
            default: e.lat = fwt + 3;
        endcase
        return e;
    endfunction

    // Memory responder: holds mem_ready low for fw (fetch) or dw (data) cycles per access.
    initial forever begin
        @(negedge clk);
        if (!mem_req) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else if (wcnt >= (iord ? dw : fw)) begin
            mem_ready = 1'b1;
            wcnt = 0;
        end else begin
            mem_ready = 1'b0;
            wcnt++;
        end
    end

    // Monitor: tracks each instruction from its first fetch cycle to retirement or trap.
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset_n) begin
            busy = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (prev_wait && fault == 2'b00) check("mem_hold", {29'd0, mem_req, mem_we, iord}, {29'd0, prev_acc});
            prev_wait = mem_req && !mem_ready;
            prev_acc  = {mem_req, mem_we, iord};
            if (!busy && mem_req && !iord) begin
                busy = 1'b1;
                cyc = 0;
                ex_alu = 4'hf;
            end
            if (busy) begin
                cyc++;
                if (alu_src_a == SRCA_RS1) ex_alu = alu_ctrl;
                if (instr_retired || fault != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_end: got retire=%0b fault=%0h, want no event", instr_retired, fault);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("latency", cyc, e.lat);
                        check("fault", {30'd0, fault}, {30'd0, e.fault});
                        check("retired", {31'd0, instr_retired}, {31'd0, !e.trap});
                        if (!e.trap) begin
                            check("exec_alu_ctrl", {28'd0, ex_alu}, {28'd0, e.alu});
                            check("final_strobes", {27'd0, reg_write, mem_to_reg, mem_we, pc_write, pc_src},
                                  {27'd0, e.rw, e.m2r, e.we, e.pcw, e.br});
                        end
                    end
                    busy = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic do_reset();
        run = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                         input int fwt, input int dwt, input bit park, input bit persist);
        exp_t e;
        int   prev, c;
        e = model(op, f3, f7, z, fwt, dwt);
        prev = done_cnt;
        c = 0;
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z; fw = fwt; dw = dwt; run = 1'b1;
        exp_q.push_back(e);
        if (park) begin
            @(posedge clk);
            #1 run = 1'b0;
        end
        while (done_cnt == prev && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (done_cnt == prev) begin
            tests++;
            fails++;
            $display("FAIL no_completion: got no retire/trap in 200 cycles, want opcode %b to finish", op);
            exp_q.delete();
            do_reset();
        end else if (e.trap) begin
            if (persist) for (int i = 0; i < 20; i++) begin
                run = i[0];
                @(posedge clk);
                #1 check("trap_quiet", {23'd0, state_dbg, fault, reg_write, mem_req, pc_write},
                         {23'd0, S_TRAP, 2'b01, 3'b000});
            end
            do_reset();
        end else if (park) begin
            check("park_idle", {27'd0, state_dbg, mem_req}, {27'd0, S_IDLE, 1'b0});
        end
    endtask

    initial begin
        int c;
        run = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", {13'd0, outs}, 32'd0);
        check("reset_state", {28'd0, state_dbg}, {28'd0, S_IDLE});

        // reset asserted in the middle of a load's data access
        opcode = OP_LOAD; funct3 = 3'b010; fw = 0; dw = 10;
        reset_n = 1'b1;
        c = 0;
        while (!(mem_req && iord) && c < 50) begin
            @(posedge clk);
            #1 c++;
        end
        check("reach_mem_rd", {28'd0, state_dbg}, {28'd0, S_MEM_RD});
        reset_n = 1'b0;
        #1 check("async_reset_outputs", {13'd0, outs}, 32'd0);
        check("async_reset_state", {28'd0, state_dbg}, {28'd0, S_IDLE});
        run = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        issue(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        issue(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        issue(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 3, 1'b0, 1'b0);
        issue(OP_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        issue(OP_BRANCH, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        issue(OP_STORE, 3'b010, 1'b0, 1'b0, 1, 2, 1'b1, 1'b0);
        issue(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        issue(OP_R, 3'b000, 1'b0, 1'b0, TMO, 0, 1'b0, 1'b0);
        issue(OP_IMM, 3'b110, 1'b1, 1'b0, TMO - 1, 0, 1'b0, 1'b0);
        issue(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, TMO, 1'b0, 1'b0);
        issue(OP_R, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        issue(OP_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            case ($urandom_range(0, 5))
                0: op = OP_R;
                1: op = OP_IMM;
                2: op = OP_LOAD;
                3: op = OP_STORE;
                4: op = OP_BRANCH;
                default: op = 7'($urandom);
            endcase
            f3 = (op == OP_LOAD || op == OP_STORE) ? 3'b010 : op == OP_BRANCH ? 3'b000 : legal_f3[$urandom_range(0, 2)];
            if ($urandom_range(0, 5) == 0) f3 = 3'($urandom);
            issue(op, f3, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 19) == 0 ? TMO : int'($urandom_range(0, TMO - 1)),
                  $urandom_range(0, 19) == 0 ? TMO : int'($urandom_range(0, TMO - 1)),
                  $urandom_range(0, 4) == 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run by t=%0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
